// File: rtl/moore_seq_detector_n.sv
// ---------------------------------------------------------------------------
// moore_seq_detector_n
//
// Multi-channel Moore serial-pattern detector. Each channel tracks how many
// leading bits of PATTERN currently match the tail of its serial input
// stream. A KMP-style automaton does the tracking. Each channel provides a
// status code, a match flag and a saturating match counter.
//
// The transition table is built at elaboration by a constant function.
// The pattern cannot be loaded at run time.
//
// Ports
//   Clock  in   1                 rising-edge clock for all state
//   R      in   1                 synchronous active-high reset (overrides all)
//   I      in   CHANNELS          serial data, bit c feeds channel c
//   S      in   CHANNELS          per-channel synchronous stop/clear of state
//   Clr    in   1                 synchronous clear of every match counter
//   Match  out  CHANNELS          bit c high while channel c is in MATCH
//   B      out  2*CHANNELS        status code of channel c on B[2c+1:2c]
//                                 00 idle, 01 partial, 10 match, 11 unused
//   Count  out  CHANNELS*CNT_W    saturating match count of channel c on
//                                 Count[(c+1)*CNT_W-1:c*CNT_W]
// ---------------------------------------------------------------------------
module moore_seq_detector_n #(
    parameter int                     CHANNELS    = 4,
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
    parameter int                     OVERLAP     = 1,
    parameter int                     CNT_W       = 8
) (
    input  logic                      Clock,
    input  logic                      R,
    input  logic [CHANNELS-1:0]       I,
    input  logic [CHANNELS-1:0]       S,
    input  logic                      Clr,
    output logic [CHANNELS-1:0]       Match,
    output logic [2*CHANNELS-1:0]     B,
    output logic [CHANNELS*CNT_W-1:0] Count
);

    // State register width: the states are 0..PATTERN_LEN.
    localparam int             SW      = $clog2(PATTERN_LEN + 1);
    // Table depth covers every encodable state value, legal or not.
    localparam int             TBL     = 1 << SW;
    localparam logic [SW-1:0]  MATCH_S = SW'(PATTERN_LEN);

    localparam logic [1:0] CODE_IDLE    = 2'b00;
    localparam logic [1:0] CODE_PARTIAL = 2'b01;
    localparam logic [1:0] CODE_MATCH   = 2'b10;

    // Compute the next matched-prefix length for one (state, bit) pair.
    // Conceptually, build the string "matched prefix of length s" followed
    // by the new bit. The result is the longest prefix of PATTERN (at most
    // PATTERN_LEN bits) that is also a suffix of that string. In the
    // non-overlapping variant, MATCH behaves like the empty state.
    function automatic logic [SW-1:0] f_next(input int s_in, input logic b);
        int            s;
        int            n;
        int            j;
        logic          found;
        logic          ok;
        logic          tbit;
        logic [SW-1:0] res;
        s = s_in;
        if (s == PATTERN_LEN && OVERLAP == 0) begin
            s = 0;
        end
        n     = s + 1;
        found = 1'b0;
        res   = '0;
        for (int k = PATTERN_LEN; k >= 1; k--) begin
            if (!found && k <= n) begin
                ok = 1'b1;
                for (int i = 0; i < PATTERN_LEN; i++) begin
                    if (i < k) begin
                        // j walks the candidate suffix. Position s is the new bit.
                        // Earlier positions are the already-matched pattern bits.
                        j = n - k + i;
                        if (j == s) begin
                            tbit = b;
                        end else begin
                            tbit = PATTERN[PATTERN_LEN-1-j];
                        end
                        if (tbit != PATTERN[PATTERN_LEN-1-i]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    found = 1'b1;
                    res   = SW'(k);
                end
            end
        end
        return res;
    endfunction

    // Map a state to its 2-bit status code. Out-of-range states report idle.
    function automatic logic [1:0] f_code(input logic [SW-1:0] st);
        logic [1:0] code;
        if (st == '0) begin
            code = CODE_IDLE;
        end else if (st == MATCH_S) begin
            code = CODE_MATCH;
        end else if (st < MATCH_S) begin
            code = CODE_PARTIAL;
        end else begin
            code = CODE_IDLE;
        end
        return code;
    endfunction

    // Shared transition tables, one per input bit value. Unreachable
    // encodings point back to state 0, so a corrupted state recovers.
    logic [SW-1:0] w_tbl0 [TBL];
    logic [SW-1:0] w_tbl1 [TBL];

    for (genvar gs = 0; gs < TBL; gs++) begin : g_tbl
        if (gs <= PATTERN_LEN) begin : g_legal
            localparam logic [SW-1:0] LP_N0 = f_next(gs, 1'b0);
            localparam logic [SW-1:0] LP_N1 = f_next(gs, 1'b1);
            assign w_tbl0[gs] = LP_N0;
            assign w_tbl1[gs] = LP_N1;
        end else begin : g_illegal
            assign w_tbl0[gs] = '0;
            assign w_tbl1[gs] = '0;
        end
    end

    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
        logic [SW-1:0]    r_state;
        logic [SW-1:0]    w_next;
        logic             r_match;
        logic [1:0]       r_code;
        logic [CNT_W-1:0] r_cnt;

        // Next-state selection. Stop discards the sample and empties the channel.
        always_comb begin
            w_next = '0;
            if (S[gc]) begin
                w_next = '0;
            end else if (I[gc]) begin
                w_next = w_tbl1[r_state];
            end else begin
                w_next = w_tbl0[r_state];
            end
        end

        // State, Moore outputs and the saturating counter for this channel.
        // The match flag and code are registered in step with the state, so
        // they remain a pure function of it.
        always_ff @(posedge Clock) begin
            if (R) begin
                r_state <= '0;
                r_match <= 1'b0;
                r_code  <= CODE_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_next;
                r_match <= (w_next == MATCH_S);
                r_code  <= f_code(w_next);
                // The counter uses the registered match of the current cycle.
                // A stop in the same cycle therefore cannot lose the detection.
                if (Clr) begin
                    r_cnt <= '0;
                end else if (r_match && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= r_cnt;
                end
            end
        end

        assign Match[gc]                  = r_match;
        assign B[2*gc +: 2]               = r_code;
        assign Count[gc*CNT_W +: CNT_W]   = r_cnt;
    end

endmodule

// File: tb/tb_moore_seq_detector_n.sv
module tb_moore_seq_detector_n;

    localparam int PL  = 4;
    localparam int PAT = 13;   // 4'b1101, first bit received is the MSB

    logic        Clock;
    logic        R;
    logic [3:0]  I;
    logic [3:0]  S;
    logic        Clr;

    logic [3:0]  m_main, m_nov, m_c2;
    logic [7:0]  b_main, b_nov, b_c2;
    logic [31:0] cnt_main, cnt_nov;
    logic [7:0]  cnt_c2;

    int total = 0;
    int bad   = 0;

    moore_seq_detector_n #(.CHANNELS(4), .PATTERN_LEN(4), .PATTERN(4'b1101),
                           .OVERLAP(1), .CNT_W(8)) dut_main (
        .Clock(Clock), .R(R), .I(I), .S(S), .Clr(Clr),
        .Match(m_main), .B(b_main), .Count(cnt_main));

    moore_seq_detector_n #(.CHANNELS(4), .PATTERN_LEN(4), .PATTERN(4'b1101),
                           .OVERLAP(0), .CNT_W(8)) dut_nov (
        .Clock(Clock), .R(R), .I(I), .S(S), .Clr(Clr),
        .Match(m_nov), .B(b_nov), .Count(cnt_nov));

    moore_seq_detector_n #(.CHANNELS(4), .PATTERN_LEN(4), .PATTERN(4'b1101),
                           .OVERLAP(1), .CNT_W(2)) dut_c2 (
        .Clock(Clock), .R(R), .I(I), .S(S), .Clr(Clr),
        .Match(m_c2), .B(b_c2), .Count(cnt_c2));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel keeps the recent input history (newest bit at bit 0).
    // The state is the longest pattern prefix that ends the history.
    int hist [3][4];
    int hlen [3][4];
    int mcnt [3][4];
    int sst  [3][4];
    int ovl  [3] = '{1, 0, 1};
    int cmax [3] = '{255, 255, 3};
    bit mvalid = 1'b0;

    function automatic int pref_len(input int h, input int hl);
        for (int k = PL; k >= 1; k--) begin
            if (k <= hl && ((h & ((1 << k) - 1)) == (PAT >> (PL - k)))) return k;
        end
        return 0;
    endfunction

    always @(posedge Clock) begin
        if (R) begin
            mvalid = 1'b1;
            for (int n = 0; n < 3; n++)
                for (int c = 0; c < 4; c++) begin
                    hist[n][c] <= 0; hlen[n][c] <= 0; mcnt[n][c] <= 0; sst[n][c] <= 0;
                end
        end else begin
            for (int n = 0; n < 3; n++)
                for (int c = 0; c < 4; c++) begin
                    automatic int nh = hist[n][c];
                    automatic int nl = hlen[n][c];
                    if (Clr) mcnt[n][c] <= 0;
                    else if (sst[n][c] == PL && mcnt[n][c] < cmax[n]) mcnt[n][c] <= mcnt[n][c] + 1;
                    if (S[c]) begin
                        nh = 0; nl = 0;
                    end else begin
                        if (ovl[n] == 0 && sst[n][c] == PL) begin nh = 0; nl = 0; end
                        nh = ((nh << 1) | int'(I[c])) & 16'hFFFF;
                        if (nl < 16) nl++;
                    end
                    hist[n][c] <= nh;
                    hlen[n][c] <= nl;
                    sst[n][c]  <= pref_len(nh, nl);
                end
        end
    end

    function automatic int dut_m(input int n, input int c);
        case (n)
            0: return int'(m_main[c]);
            1: return int'(m_nov[c]);
            default: return int'(m_c2[c]);
        endcase
    endfunction

    function automatic int dut_b(input int n, input int c);
        case (n)
            0: return int'((b_main >> (2*c)) & 8'h3);
            1: return int'((b_nov >> (2*c)) & 8'h3);
            default: return int'((b_c2 >> (2*c)) & 8'h3);
        endcase
    endfunction

    function automatic int dut_c(input int n, input int c);
        case (n)
            0: return int'((cnt_main >> (8*c)) & 32'hFF);
            1: return int'((cnt_nov >> (8*c)) & 32'hFF);
            default: return int'((cnt_c2 >> (2*c)) & 8'h3);
        endcase
    endfunction

    // Compare every output of every instance against the model, off the active edge.
    always @(negedge Clock) begin
        if (mvalid) begin
            for (int n = 0; n < 3; n++)
                for (int c = 0; c < 4; c++) begin
                    automatic int eb = (sst[n][c] == 0) ? 0 : ((sst[n][c] == PL) ? 2 : 1);
                    chk($sformatf("model_match[%0d][%0d]", n, c), dut_m(n, c), int'(sst[n][c] == PL));
                    chk($sformatf("model_b[%0d][%0d]", n, c), dut_b(n, c), eb);
                    chk($sformatf("model_count[%0d][%0d]", n, c), dut_c(n, c), mcnt[n][c]);
                end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic [3:0] iv, input logic [3:0] sv, input logic clr, input logic r);
        I = iv; S = sv; Clr = clr; R = r;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        logic [3:0] p;
        logic [3:0] s1;
        int         exp_c2 [4] = '{1, 2, 3, 3};
        p  = 4'b1101;
        s1 = 4'b0010;
        I = 4'h0; S = 4'h0; Clr = 1'b0; R = 1'b1;

        // Reset with random data and stop inputs.
        cyc(4'($urandom), 4'($urandom), 1'b0, 1'b1);
        cyc(4'($urandom), 4'($urandom), 1'b0, 1'b1);
        chk("rst_match", int'(m_main), 0);
        chk("rst_b", int'(b_main), 0);
        chk("rst_count", int'(cnt_main), 0);

        // Channel 0 receives 1101.
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("ch0_partial_b", int'(b_main[1:0]), 1);
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        chk("ch0_match", int'(m_main[0]), 1);
        chk("ch0_match_b", int'(b_main[1:0]), 2);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("ch0_count1", int'(cnt_main[7:0]), 1);
        chk("ch0_match_gone", int'(m_main[0]), 0);

        // Channel 0 receives 1101101, then a 0 so the last match is counted.
        for (int j = 0; j < 7; j++) cyc({3'b000, p[3 - (j % 3 == 0 && j > 0 ? 0 : 0) - 0 + 0 - 0]} & 4'h0 | {3'b000, (j == 2 || j == 5) ? 1'b0 : 1'b1}, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("ovl_count", int'(cnt_main[7:0]), 3);
        chk("novl_count", int'(cnt_nov[7:0]), 2);

        // Channel 1 receives 110, then a stop arrives with I=1, then 1101.
        cyc(4'b0010, 4'h0, 1'b0, 1'b0);
        cyc(4'b0010, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        cyc(4'b0010, s1, 1'b0, 1'b0);
        chk("ch1_stop_b", int'(b_main[3:2]), 0);
        chk("ch1_stop_match", int'(m_main[1]), 0);
        cyc(4'b0010, 4'h0, 1'b0, 1'b0);
        cyc(4'b0010, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("ch1_resume_nomatch", int'(m_main[1]), 0);
        cyc(4'b0010, 4'h0, 1'b0, 1'b0);
        chk("ch1_resume_match", int'(m_main[1]), 1);
        chk("ch0_untouched_b", int'(b_main[1:0]), 0);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("ch0_untouched_count", int'(cnt_main[7:0]), 3);

        // Channel 2 receives 1101 five times back to back; the 2-bit counter saturates.
        for (int j = 0; j < 20; j++) begin
            cyc({1'b0, p[3 - (j % 4)], 2'b00}, 4'h0, 1'b0, 1'b0);
            if (j >= 4 && (j % 4) == 0) chk("c2_sat_seq", int'(cnt_c2[5:4]), exp_c2[j/4 - 1]);
        end
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        chk("c2_sat_final", int'(cnt_c2[5:4]), 3);
        chk("main_ch2_count", int'(cnt_main[23:16]), 5);
        for (int j = 0; j < 4; j++) cyc({1'b0, p[3 - j], 2'b00}, 4'h0, 1'b0, 1'b0);
        chk("c2_match_before_clr", int'(m_c2[2]), 1);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        chk("c2_clr_with_match", int'(cnt_c2[5:4]), 0);
        chk("main_clr_all", int'(cnt_main), 0);

        // Distinct streams on all channels; channel 3 reaches state 3, then reset.
        cyc({1'b1, 1'($urandom), 1'b1, 1'b1}, 4'h0, 1'b0, 1'b0);
        cyc({1'b1, 1'($urandom), 1'b0, 1'b1}, 4'h0, 1'b0, 1'b0);
        cyc({1'b0, 1'($urandom), 1'b1, 1'b1}, 4'h0, 1'b0, 1'b0);
        chk("ch3_state3_b", int'(b_main[7:6]), 1);
        cyc(4'($urandom), 4'h0, 1'b0, 1'b1);
        chk("midrst_match", int'(m_main), 0);
        chk("midrst_b", int'(b_main), 0);
        chk("midrst_count", int'(cnt_main), 0);
        cyc({1'b1, 3'($urandom)}, 4'h0, 1'b0, 1'b0);
        cyc({1'b1, 3'($urandom)}, 4'h0, 1'b0, 1'b0);
        cyc({1'b0, 3'($urandom)}, 4'h0, 1'b0, 1'b0);
        chk("ch3_rematch_pending", int'(m_main[3]), 0);
        cyc({1'b1, 3'($urandom)}, 4'h0, 1'b0, 1'b0);
        chk("ch3_rematch", int'(m_main[3]), 1);

        // Random traffic with occasional stops, clears and resets, checked by the model.
        for (int j = 0; j < 300; j++) begin
            cyc(4'($urandom),
                {($urandom_range(7) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(7) == 0)},
                ($urandom_range(31) == 0), ($urandom_range(63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
